// File: rtl/sal_sched_pkg.sv
// Shared types and helpers for the DRAM command scheduler.
package sal_sched_pkg;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    ACT = 3'd1,
    RD  = 3'd2,
    WR  = 3'd3,
    PRE = 3'd4
  } cmd_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width of a down-counter that must hold t_max-1 without overflow.
  function automatic int timer_w(input int t_max);
    return (t_max < 2) ? 1 : $clog2(t_max + 1);
  endfunction

endpackage

// File: rtl/sal_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping to 0.
module sal_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr + IW'(k);
      if (req[idx]) begin
        gnt_idx = idx;
        any     = 1'b1;
      end
    end
    if (any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/sal_dram_cmd_scheduler.sv
// Arbitrates per-bank DRAM commands onto one command bus with inter-bank timing.
module sal_dram_cmd_scheduler
  import sal_sched_pkg::*;
#(
  parameter int BK_CNT = 4,
  parameter int RA_W   = 14,
  parameter int CA_W   = 10,
  parameter int T_RRD  = 2,
  parameter int T_CCD  = 2,
  parameter int T_WTR  = 4,
  parameter int T_RTW  = 4,
  localparam int BA_W  = $clog2(BK_CNT),
  localparam int AW    = max2(RA_W, CA_W)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [BK_CNT-1:0]              req_valid,
  input  logic [BK_CNT-1:0][2:0]         req_cmd,
  input  logic [BK_CNT-1:0][RA_W-1:0]    req_ra,
  input  logic [BK_CNT-1:0][CA_W-1:0]    req_ca,
  output logic [BK_CNT-1:0]              req_ready,
  output cmd_t                           cmd_o,
  output logic [BA_W-1:0]                ba_o,
  output logic [AW-1:0]                  addr_o
);

  localparam int TW = timer_w(max2(max2(T_RRD, T_CCD), max2(T_WTR, T_RTW)));

  logic [TW-1:0]     rrd_cnt, ccd_cnt, wtr_cnt, rtw_cnt;
  logic [BA_W-1:0]   rr_ptr;
  logic [BK_CNT-1:0] col_elig, row_elig, col_gnt, row_gnt, gnt;
  logic [BA_W-1:0]   col_idx, row_idx, gnt_idx;
  logic              col_any, row_any, gnt_any;
  logic [2:0]        gnt_cmd;

  for (genvar gi = 0; gi < BK_CNT; gi++) begin : g_bank
    assign col_elig[gi] = req_valid[gi] && (ccd_cnt == '0) &&
                          (((req_cmd[gi] == RD) && (wtr_cnt == '0)) ||
                           ((req_cmd[gi] == WR) && (rtw_cnt == '0)));
    assign row_elig[gi] = req_valid[gi] &&
                          (((req_cmd[gi] == ACT) && (rrd_cnt == '0)) ||
                           (req_cmd[gi] == PRE));

    a_hold_valid : assert property (@(posedge clk) disable iff (!rst_n)
      (req_valid[gi] && !req_ready[gi]) |=> req_valid[gi])
      else $error("bank %0d dropped req_valid before being granted", gi);
  end

  sal_rr_arbiter #(.N(BK_CNT)) u_col_arb (
    .req     (col_elig),
    .ptr     (rr_ptr),
    .gnt     (col_gnt),
    .gnt_idx (col_idx),
    .any     (col_any)
  );

  sal_rr_arbiter #(.N(BK_CNT)) u_row_arb (
    .req     (row_elig),
    .ptr     (rr_ptr),
    .gnt     (row_gnt),
    .gnt_idx (row_idx),
    .any     (row_any)
  );

  // Any eligible column command pre-empts the row level entirely.
  assign gnt       = col_any ? col_gnt : row_gnt;
  assign gnt_idx   = col_any ? col_idx : row_idx;
  assign gnt_any   = col_any | row_any;
  assign gnt_cmd   = req_cmd[gnt_idx];
  assign req_ready = rst_n ? gnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrd_cnt <= '0;
      ccd_cnt <= '0;
      wtr_cnt <= '0;
      rtw_cnt <= '0;
      rr_ptr  <= '0;
      cmd_o   <= NOP;
      ba_o    <= '0;
      addr_o  <= '0;
    end else begin
      rrd_cnt <= (gnt_any && gnt_cmd == ACT) ? TW'(T_RRD - 1)
               : (rrd_cnt != '0) ? rrd_cnt - TW'(1) : rrd_cnt;
      ccd_cnt <= (gnt_any && (gnt_cmd == RD || gnt_cmd == WR)) ? TW'(T_CCD - 1)
               : (ccd_cnt != '0) ? ccd_cnt - TW'(1) : ccd_cnt;
      wtr_cnt <= (gnt_any && gnt_cmd == WR) ? TW'(T_WTR - 1)
               : (wtr_cnt != '0) ? wtr_cnt - TW'(1) : wtr_cnt;
      rtw_cnt <= (gnt_any && gnt_cmd == RD) ? TW'(T_RTW - 1)
               : (rtw_cnt != '0) ? rtw_cnt - TW'(1) : rtw_cnt;
      if (gnt_any) begin
        rr_ptr <= gnt_idx + BA_W'(1);
        cmd_o  <= cmd_t'(gnt_cmd);
        ba_o   <= gnt_idx;
        if (gnt_cmd == ACT)
          addr_o <= AW'(req_ra[gnt_idx]);
        else if (gnt_cmd == RD || gnt_cmd == WR)
          addr_o <= AW'(req_ca[gnt_idx]);
        else
          addr_o <= '0;
      end else begin
        cmd_o  <= NOP;
        ba_o   <= '0;
        addr_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sal_dram_cmd_scheduler.sv
// Directed bench: expected grants are scripted, expected bus outputs go through a scoreboard queue.
module tb_sal_dram_cmd_scheduler;
  import sal_sched_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        req_valid;
  logic [3:0][2:0]   req_cmd;
  logic [3:0][13:0]  req_ra;
  logic [3:0][9:0]   req_ca;
  logic [3:0]        req_ready;
  cmd_t              cmd_o;
  logic [1:0]        ba_o;
  logic [13:0]       addr_o;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [1:0]  ba;
    logic [13:0] addr;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   fail_cnt = 0;

  sal_dram_cmd_scheduler #(
    .BK_CNT(4), .RA_W(14), .CA_W(10),
    .T_RRD(2), .T_CCD(2), .T_WTR(4), .T_RTW(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_ra    (req_ra),
    .req_ca    (req_ca),
    .req_ready (req_ready),
    .cmd_o     (cmd_o),
    .ba_o      (ba_o),
    .addr_o    (addr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int b, input logic [2:0] c);
    req_valid[b] = 1'b1;
    req_cmd[b]   = c;
    req_ra[b]    = 14'h1A0 + 14'(b);
    req_ca[b]    = 10'h0C0 + 10'(b);
  endtask

  function automatic logic [13:0] exp_addr(input int b);
    case (req_cmd[b])
      ACT:     return req_ra[b];
      RD, WR:  return {4'b0, req_ca[b]};
      default: return 14'h0;
    endcase
  endfunction

  // One cycle: check the grant, retire last cycle's expected output, queue this cycle's.
  task automatic step(input logic [3:0] exp_gnt, input bit keep, input string tag);
    exp_t e;
    int   g;
    g = -1;
    for (int i = 0; i < 4; i++) if (exp_gnt[i]) g = i;
    @(negedge clk);
    check({tag, ".ready"}, 32'(req_ready), 32'(exp_gnt));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".cmd_o"},  32'(cmd_o),  32'(e.cmd));
      check({tag, ".ba_o"},   32'(ba_o),   32'(e.ba));
      check({tag, ".addr_o"}, 32'(addr_o), 32'(e.addr));
    end
    e = '0;
    if (g >= 0) begin
      e.cmd  = req_cmd[g];
      e.ba   = 2'(g);
      e.addr = exp_addr(g);
      $display("t=%0t %s: grant bank %0d cmd %0d addr %0h", $time, tag, g, e.cmd, e.addr);
    end else begin
      $display("t=%0t %s: no grant", $time, tag);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (g >= 0 && !keep) req_valid[g] = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, ".ready"},  32'(req_ready), 32'h0);
    check({tag, ".cmd_o"},  32'(cmd_o),     32'(NOP));
    check({tag, ".ba_o"},   32'(ba_o),      32'h0);
    check({tag, ".addr_o"}, 32'(addr_o),    32'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_cmd   = '0;
    req_ra    = '0;
    req_ca    = '0;
    set_req(0, PRE);
    set_req(2, PRE);
    repeat (3) @(posedge clk);
    check_reset_state("in_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    step(4'b0001, 0, "rst_first");
    step(4'b0100, 0, "rr_skip");
    step(4'b0000, 0, "idle0");

    // Pointer sits at 3: bank 3 before bank 0, then wrap.
    set_req(0, PRE);
    set_req(3, PRE);
    step(4'b1000, 0, "wrap_b3");
    step(4'b0001, 0, "wrap_b0");

    for (int b = 0; b < 4; b++) set_req(b, PRE);
    step(4'b0010, 1, "rr_fair");
    step(4'b0100, 1, "rr_fair");
    step(4'b1000, 1, "rr_fair");
    step(4'b0001, 1, "rr_fair");
    step(4'b0010, 0, "rr_fair");
    step(4'b0100, 0, "rr_fair");
    step(4'b1000, 0, "rr_fair");
    step(4'b0001, 0, "rr_fair");
    step(4'b0000, 0, "idle1");

    set_req(2, ACT);
    set_req(3, ACT);
    step(4'b0100, 0, "trrd_n");
    step(4'b0000, 0, "trrd_n1");
    step(4'b1000, 0, "trrd_n2");
    step(4'b0000, 0, "trrd_gap");

    set_req(0, ACT);
    set_req(1, RD);
    step(4'b0010, 0, "colprio_rd");
    step(4'b0001, 0, "colprio_act");
    step(4'b0000, 0, "idle2");
    step(4'b0000, 0, "idle3");

    set_req(2, WR);
    set_req(3, RD);
    step(4'b0100, 0, "twtr_wr");
    step(4'b0000, 0, "twtr_w1");
    step(4'b0000, 0, "twtr_w2");
    step(4'b0000, 0, "twtr_w3");
    step(4'b1000, 0, "twtr_rd");

    set_req(0, WR);
    step(4'b0000, 0, "trtw_w1");
    step(4'b0000, 0, "trtw_w2");
    step(4'b0000, 0, "trtw_w3");
    step(4'b0001, 0, "trtw_wr");

    set_req(1, RD);
    set_req(2, RD);
    step(4'b0000, 0, "tccd_w1");
    step(4'b0000, 0, "tccd_w2");
    step(4'b0000, 0, "tccd_w3");
    step(4'b0010, 0, "tccd_rd0");
    step(4'b0000, 0, "tccd_gap");
    step(4'b0100, 0, "tccd_rd1");
    step(4'b0000, 0, "idle4");

    // Reset lands right after bank 3 issues, with all banks still requesting.
    for (int b = 0; b < 4; b++) set_req(b, PRE);
    step(4'b1000, 1, "pre_rst");
    rst_n = 1'b0;
    check_reset_state("mid_reset");
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(4'b0001, 0, "post_rst");
    step(4'b0010, 0, "post_rst");
    step(4'b0100, 0, "post_rst");
    step(4'b1000, 0, "post_rst");
    step(4'b0000, 0, "final");

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule
